// File: rtl/counter_pkg.sv
// Shared constants for the cascadable digit counter: count width,
// active-low 7-segment glyph table and the terminal-count helper.
package counter_pkg;

  localparam int COUNT_W = 4;

  // Active-low segments {g,f,e,d,c,b,a}; 10..15 show A,b,C,d,E,F.
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Count value from which the next enabled edge wraps.
  function automatic logic [COUNT_W-1:0] terminal_val(
    input logic up,
    input int   mod
  );
    logic [COUNT_W-1:0] top;
    top = COUNT_W'(mod - 1);
    return up ? top : '0;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to active-low 7-segment decoder.
// Ports: val (4-bit digit in), seg ({g,f,e,d,c,b,a}, active-low out).
module seg7_decode
  import counter_pkg::*;
(
  input  logic [COUNT_W-1:0] val,
  output logic [6:0]         seg
);

  assign seg = SEG_PATTERN[val];

endmodule

// File: rtl/cascade_digit_counter.sv
// Cascadable modulo-MOD up/down digit counter with load and sticky wrap.
// Ports: ck, rst_n (async low), ci (count enable), up, ld, din[3:0],
//   clr_wrap, Qa..Qd (count, Qa=LSB), Rc (comb carry), wrap,
//   seg[6:0] (active-low, only when SEG7_EN is defined).
module cascade_digit_counter
  import counter_pkg::*;
#(
  parameter int MOD  = 10,
  parameter int INIT = 0
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               ci,
  input  logic               up,
  input  logic               ld,
  input  logic [COUNT_W-1:0] din,
  input  logic               clr_wrap,
  output logic               Qa,
  output logic               Qb,
  output logic               Qc,
  output logic               Qd,
  output logic               Rc,
`ifdef SEG7_EN
  output logic [6:0]         seg,
`endif
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] MAXV  = COUNT_W'(MOD - 1);
  localparam logic [COUNT_W-1:0] INITV = COUNT_W'(INIT);
  localparam logic [COUNT_W:0]   MODX  = (COUNT_W+1)'(MOD);

  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_nx;
  logic               at_term;

  assign at_term = (count == terminal_val(up, MOD));
  assign Rc      = ci & ~ld & at_term;

  always_comb begin
    count_nx = count;
    if (ld) begin
      count_nx = ({1'b0, din} >= MODX) ? MAXV : din;
    end else if (ci) begin
      if (up)
        count_nx = at_term ? '0 : count + 1'b1;
      else
        count_nx = at_term ? MAXV : count - 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      count <= INITV;
      wrap  <= 1'b0;
    end else begin
      count <= count_nx;
      // Set wins over a same-edge clear.
      if (Rc)
        wrap <= 1'b1;
      else if (clr_wrap)
        wrap <= 1'b0;
    end
  end

  assign {Qd, Qc, Qb, Qa} = count;

`ifdef SEG7_EN
  logic [6:0] seg_nx;

  // Decode the next count so the registered glyph lines up with Q.
  seg7_decode u_dec (
    .val (count_nx),
    .seg (seg_nx)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)
      seg <= SEG_PATTERN[INITV];
    else
      seg <= seg_nx;
  end
`endif

endmodule

// File: tb/tb_cascade_digit_counter.sv
// Directed self-checking bench for cascade_digit_counter (MOD=10),
// including a two-digit units->tens cascade.
module tb_cascade_digit_counter;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       ci;
  logic       up;
  logic       ld;
  logic [3:0] din;
  logic       clr_wrap;
  logic       ua, ub, uc, ud, u_rc, u_wrap;
  logic       ta, tb, tc, td, t_rc, t_wrap;
`ifdef SEG7_EN
  logic [6:0] u_seg;
  logic [6:0] t_seg;
`endif
  int total = 0;
  int passed = 0;

  always #10 ck = ~ck;

  cascade_digit_counter #(.MOD(10), .INIT(0)) u_units (
`ifdef SEG7_EN
    .seg      (u_seg),
`endif
    .ck       (ck),
    .rst_n    (rst_n),
    .ci       (ci),
    .up       (up),
    .ld       (ld),
    .din      (din),
    .clr_wrap (clr_wrap),
    .Qa       (ua),
    .Qb       (ub),
    .Qc       (uc),
    .Qd       (ud),
    .Rc       (u_rc),
    .wrap     (u_wrap)
  );

  cascade_digit_counter #(.MOD(10), .INIT(0)) u_tens (
`ifdef SEG7_EN
    .seg      (t_seg),
`endif
    .ck       (ck),
    .rst_n    (rst_n),
    .ci       (u_rc),
    .up       (up),
    .ld       (1'b0),
    .din      (4'd0),
    .clr_wrap (clr_wrap),
    .Qa       (ta),
    .Qb       (tb),
    .Qc       (tc),
    .Qd       (td),
    .Rc       (t_rc),
    .wrap     (t_wrap)
  );

  wire [3:0] uq = {ud, uc, ub, ua};
  wire [3:0] tq = {td, tc, tb, ta};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ci = 1'b0; up = 1'b1; ld = 1'b0;
    din = 4'd0; clr_wrap = 1'b0;
    #25;
    chk("rst_q", 32'(uq), 0);
    chk("rst_wrap", 32'(u_wrap), 0);
    chk("rst_rc", 32'(u_rc), 0);
`ifdef SEG7_EN
    chk("rst_seg", 32'(u_seg), 32'b1000000);
`endif
    @(negedge ck);
    rst_n = 1'b1;
    tick();

    // Up count through a full wrap.
    ci = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      chk("up_rc", 32'(u_rc), ((i - 1) == 9) ? 1 : 0);
      tick();
      chk("up_q", 32'(uq), 32'(i % 10));
      chk("up_wrap", 32'(u_wrap), (i == 10) ? 1 : 0);
    end

    // Clear alone, then clear colliding with a wrap.
    ci = 1'b0; clr_wrap = 1'b1;
    tick();
    chk("clr_wrap", 32'(u_wrap), 0);
    chk("hold_q", 32'(uq), 0);
    clr_wrap = 1'b0; ld = 1'b1; din = 4'd9;
    tick();
    chk("ld9_q", 32'(uq), 9);
    ld = 1'b0; ci = 1'b1; clr_wrap = 1'b1;
    #1;
    chk("rc_at9", 32'(u_rc), 1);
    tick();
    chk("set_wins_q", 32'(uq), 0);
    chk("set_wins_wrap", 32'(u_wrap), 1);
    clr_wrap = 1'b0;

    // Async reset mid-count at 7 with wrap set.
    ci = 1'b0; ld = 1'b1; din = 4'd7;
    tick();
    chk("ld7_q", 32'(uq), 7);
    ld = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(uq), 0);
    chk("async_rst_wrap", 32'(u_wrap), 0);
    @(negedge ck);
    rst_n = 1'b1;

    // Down wrap from 0.
    @(posedge ck); #1;
    ld = 1'b1; din = 4'd0; up = 1'b0; ci = 1'b1;
    #1;
    chk("dn_rc_ld", 32'(u_rc), 0);
    tick();
    ld = 1'b0;
    #1;
    chk("dn_rc_at0", 32'(u_rc), 1);
    tick();
    chk("dn_q9", 32'(uq), 9);
    chk("dn_rc_at9", 32'(u_rc), 0);
    chk("dn_wrap", 32'(u_wrap), 1);
    tick();
    chk("dn_q8", 32'(uq), 8);
`ifdef SEG7_EN
    chk("seg_8", 32'(u_seg), 32'b0000000);
`endif

    // Clamped load never sets wrap and gates Rc.
    ci = 1'b0; clr_wrap = 1'b1;
    tick();
    clr_wrap = 1'b0;
    ld = 1'b1; din = 4'd12; ci = 1'b1; up = 1'b1;
    tick();
    chk("ld12_q", 32'(uq), 9);
    chk("ld12_rc", 32'(u_rc), 0);
    tick();
    chk("ld12_hold", 32'(uq), 9);
    chk("ld12_wrap", 32'(u_wrap), 0);
    ld = 1'b0; ci = 1'b0;
    tick();
    chk("ci0_hold", 32'(uq), 9);

    // Two-digit synchronous cascade 00 -> 99 -> 00.
    #3;
    rst_n = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    ci = 1'b1; up = 1'b1;
    for (int n = 0; n < 100; n++) begin
      chk("casc_val", 32'({tq, uq}), 32'({4'(n / 10), 4'(n % 10)}));
      chk("casc_trc", 32'(t_rc), (n == 99) ? 1 : 0);
      @(posedge ck); #1;
    end
    chk("casc_end", 32'({tq, uq}), 0);
    chk("casc_twrap", 32'(t_wrap), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
